reg_file_64: RTL and testbench

//  - Architectural register file directly upstream of the 64-bit ALU: supplies operands a/b

---
 rtl/reg_file_64.sv | 103 ++++++++++
 tb/tb_reg_file_64.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_64.sv
// reg_file_64: architectural register file feeding the 64-bit ALU.
//  - Two combinational read ports (rd1/rd2), one clocked write port (we3/wa3/wd3).
//  - Index ZERO_REG is XZR: it always reads 0, and writes to it are dropped.
//  - Holds the NZCV flag register, captured from the ALU when flag_we is high.
//  - Optional build macro REG_FILE_BYPASS_EN: when defined, a write is forwarded to a
//    read port that reads the same address in the same cycle. When it is undefined,
//    the new value becomes visible on the cycle after the write edge.
//  - Flags are never forwarded.
module reg_file_64 #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  output logic [3:0]        flags
);

  localparam int unsigned       NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]             we_dec;
  logic [3:0]                      flags_q;
  logic                            wr_valid;

  // A write counts only when it is enabled and does not target XZR.
  assign wr_valid = we3 && (wa3 != ZERO_ADDR);

  // One-hot write decode; the XZR slot can never be selected.
  always_comb begin
    we_dec = '0;
    if (wr_valid) begin
      we_dec[wa3] = 1'b1;
    end
  end

  // Register storage. The XZR entry has a constant-0 enable, so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_dec[i]) begin
          regs_q[i] <= wd3;
        end
      end
    end
  end

  // NZCV capture, independent of the register write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= flags_in;
    end
  end

  assign flags = flags_q;

  // Read port 1: XZR masking, optional write-through, forced 0 while in reset.
  always_comb begin
    rd1 = regs_q[ra1];
    if (ra1 == ZERO_ADDR) begin
      rd1 = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_valid && (wa3 == ra1)) begin
      rd1 = wd3;
    end
`endif
    if (!rst_n) begin
      rd1 = '0;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = regs_q[ra2];
    if (ra2 == ZERO_ADDR) begin
      rd2 = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_valid && (wa3 == ra2)) begin
      rd2 = wd3;
    end
`endif
    if (!rst_n) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_64.sv
// tb_reg_file_64: directed scenarios followed by randomized traffic, all checked against
// a behavioural array model of the register file and flags.
module tb_reg_file_64;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa3;
  logic [63:0] rd1, rd2, wd3;
  logic        we3, flag_we;
  logic [3:0]  flags_in, flags;

  // Reference model state
  logic [63:0] mem [32];
  logic [3:0]  fl;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .flag_we  (flag_we),
    .flags_in (flags_in),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $error("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    fl = 4'b0000;
  endtask

  task automatic set_reset(input logic v);
    rst_n = v;
    if (!v) model_clear();
  endtask

  // Expected combinational read for the current inputs.
  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (!rst_n) return 64'd0;
    if (ra == 5'd31) return 64'd0;
`ifdef REG_FILE_BYPASS_EN
    if (we3 && wa3 == ra) return wd3;
`endif
    return mem[ra];
  endfunction

  // Rising edge: update the model from the applied inputs, then settle.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we3 && wa3 != 5'd31) mem[wa3] = wd3;
      if (flag_we) fl = flags_in;
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rd1"}, rd1, exp_rd(ra1));
    chk({tag, "_rd2"}, rd2, exp_rd(ra2));
    chk({tag, "_flags"}, {60'd0, flags}, {60'd0, fl});
  endtask

  task automatic idle();
    we3 = 1'b0; flag_we = 1'b0; wa3 = '0; wd3 = '0; flags_in = '0;
  endtask

  initial begin
    model_clear();
    ra1 = 5'd3; ra2 = 5'd9;
    idle();
    set_reset(1'b0);
    #3;
    check_all("reset_hold");
    @(negedge clk);
    set_reset(1'b1);

    // Write/read of X3 on both ports
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd3; wd3 = 64'hDEAD_BEEF_0123_4567;
    tick();
    @(negedge clk);
    idle(); ra1 = 5'd3; ra2 = 5'd3;
    #1;
    chk("x3_rd1", rd1, 64'hDEAD_BEEF_0123_4567);
    chk("x3_rd2", rd2, 64'hDEAD_BEEF_0123_4567);

    // Fill X0..X30 with distinct values, then attempt an XZR write
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      we3 = 1'b1; wa3 = 5'(i); wd3 = {$urandom, $urandom};
      tick();
    end
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFFFF_FFFF_FFFF_FFFF; ra1 = 5'd31; ra2 = 5'd0;
    #1;
    chk("xzr_before", rd1, 64'd0);
    tick();
    chk("xzr_after", rd1, 64'd0);
    @(negedge clk);
    idle();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk("sweep_rd1", rd1, exp_rd(ra1));
      chk("sweep_rd2", rd2, exp_rd(ra2));
    end

    // Same-cycle write/read hazard on X7
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'd10;
    tick();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'd20; ra1 = 5'd7; ra2 = 5'd3;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("hazard_same", rd1, 64'd20);
`else
    chk("hazard_same", rd1, 64'd10);
`endif
    tick();
    @(negedge clk);
    idle();
    #1;
    chk("hazard_next", rd1, 64'd20);

    // Flag capture and hold
    @(negedge clk);
    flag_we = 1'b1; flags_in = 4'b0100;
    #1;
    chk("flags_no_bypass", {60'd0, flags}, 64'd0);
    tick();
    chk("flags_cap", {60'd0, flags}, 64'h4);
    @(negedge clk);
    flag_we = 1'b0; flags_in = 4'b1011;
    tick();
    chk("flags_hold", {60'd0, flags}, 64'h4);

    // Concurrent write and flag capture
    @(negedge clk);
    idle(); flag_we = 1'b1; flags_in = 4'b1001;
    tick();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd1; wd3 = 64'd0; flag_we = 1'b1; flags_in = 4'b0100; ra1 = 5'd1;
    tick();
    chk("conc_x1", rd1, 64'd0);
    chk("conc_flags", {60'd0, flags}, 64'h4);

    // Reset asserted in the same cycle as a write and a flag capture; X5 written first
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd5; wd3 = 64'h5555_0000_AAAA_1111; flag_we = 1'b0;
    tick();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd1; wd3 = 64'h1234; flag_we = 1'b1; flags_in = 4'b1011;
    ra1 = 5'd5; ra2 = 5'd1;
    set_reset(1'b0);
    #1;
    chk("rst_async_rd1", rd1, 64'd0);
    chk("rst_async_rd2", rd2, 64'd0);
    chk("rst_async_flags", {60'd0, flags}, 64'd0);
    tick();
    check_all("rst_edge");
    @(negedge clk);
    idle();
    set_reset(1'b1);
    #1;
    chk("rst_x5", rd1, 64'd0);
    chk("rst_x1", rd2, 64'd0);
    chk("rst_flags", {60'd0, flags}, 64'd0);

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      set_reset(($urandom_range(0, 39) != 0));
      ra1 = 5'($urandom); ra2 = 5'($urandom_range(0, 3) == 0 ? ra1 : 5'($urandom));
      we3 = 1'($urandom); wa3 = 5'($urandom_range(0, 2) == 0 ? ra1 : 5'($urandom));
      wd3 = {$urandom, $urandom};
      flag_we = 1'($urandom); flags_in = 4'($urandom);
      #1;
      check_all("rnd_pre");
      tick();
      check_all("rnd_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
